// File: rtl/branch_stack_ctrl.sv
// rtl/branch_stack_ctrl.sv - branch-stack checkpoint allocator/retirer for 2-way dispatch
//
// Purpose: hands out branch-stack entries (BS_PTR + B_MASK) to up to two
// dispatching branches per cycle, tracks each entry's dependence on older
// branches, and turns branch FU resolutions into clear/squash broadcasts.
// After a squash, dispatch is held for RECOV_CYCLES cycles while the front
// end redirects.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   disp_br_req[1:0]    per-slot branch dispatch request
//   disp_stall          hold dispatch, nothing allocated this cycle
//   disp_ptr0/1         entry granted to slot 0/1
//   disp_bmask0/1       older unresolved branch mask for slot 0/1
//   cur_bmask           registered mask of live branches
//   res_valid/wrong/ptr/recov_NPC  registered branch FU resolution
//   squash, squash_mask, recov_NPC  mispredict broadcast
//   clear_valid, clear_ptr          correct-prediction broadcast
//   free_count          registered number of free entries
module branch_stack_ctrl #(
  parameter int NUM_BS       = 4,
  parameter int PTR_W        = 2,
  parameter int RECOV_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        disp_br_req,
  output logic              disp_stall,
  output logic [PTR_W-1:0]  disp_ptr0,
  output logic [PTR_W-1:0]  disp_ptr1,
  output logic [NUM_BS-1:0] disp_bmask0,
  output logic [NUM_BS-1:0] disp_bmask1,
  output logic [NUM_BS-1:0] cur_bmask,
  input  logic              res_valid,
  input  logic              res_wrong,
  input  logic [PTR_W-1:0]  res_ptr,
  input  logic [63:0]       res_recov_NPC,
  output logic              squash,
  output logic [NUM_BS-1:0] squash_mask,
  output logic [63:0]       recov_NPC,
  output logic              clear_valid,
  output logic [PTR_W-1:0]  clear_ptr,
  output logic [PTR_W:0]    free_count
);

  localparam int CNT_W = (RECOV_CYCLES > 1) ? $clog2(RECOV_CYCLES) : 1;

  typedef enum logic { NORMAL, RECOVER } state_t;

  state_t              state;
  logic [CNT_W-1:0]    recov_cnt;
  logic [NUM_BS-1:0]   live_q;              // doubles as cur_bmask
  logic [NUM_BS-1:0]   dep_q [NUM_BS];
  logic [PTR_W:0]      free_q;

  logic [NUM_BS-1:0]   res_oh;
  logic                res_live;
  logic [NUM_BS-1:0]   clr;
  logic [NUM_BS-1:0]   sq_mask;
  logic [PTR_W:0]      n_req;
  logic [PTR_W:0]      n_alloc;
  logic [PTR_W:0]      n_freed;
  logic [PTR_W-1:0]    low0, low1;
  logic                found0, found1;
  logic [PTR_W-1:0]    ptr0, ptr1;
  logic [NUM_BS-1:0]   p0_oh, p1_oh;
  logic [NUM_BS-1:0]   bm0, bm1;
  logic                stall;
  logic                alloc0, alloc1;
  logic [NUM_BS-1:0]   alloc_mask;

  always_comb begin
    res_oh          = '0;
    res_oh[res_ptr] = 1'b1;
    res_live        = live_q[res_ptr];

    // Resolutions of already-squashed entries are dropped here.
    squash      = res_valid & res_wrong & res_live;
    clear_valid = res_valid & ~res_wrong & res_live;
    clr         = clear_valid ? res_oh : '0;

    sq_mask = '0;
    if (squash) begin
      sq_mask = res_oh;
      for (int i = 0; i < NUM_BS; i++) begin
        if (live_q[i] && dep_q[i][res_ptr]) sq_mask[i] = 1'b1;
      end
    end

    // Freed-this-cycle entries stay marked live for the search, so they
    // only become allocatable next cycle.
    low0   = '0;
    low1   = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    for (int i = 0; i < NUM_BS; i++) begin
      if (!live_q[i]) begin
        if (!found0) begin
          low0   = PTR_W'(i);
          found0 = 1'b1;
        end else if (!found1) begin
          low1   = PTR_W'(i);
          found1 = 1'b1;
        end
      end
    end

    ptr0 = low0;
    ptr1 = disp_br_req[0] ? low1 : low0;
    p0_oh        = '0;
    p0_oh[ptr0]  = 1'b1;
    p1_oh        = '0;
    p1_oh[ptr1]  = 1'b1;

    bm0 = live_q & ~clr;
    bm1 = bm0 | (disp_br_req[0] ? p0_oh : '0);

    n_req = {{PTR_W{1'b0}}, disp_br_req[0]} + {{PTR_W{1'b0}}, disp_br_req[1]};
    stall = (n_req > free_q) || (state == RECOVER) || squash;

    alloc0     = ~stall & disp_br_req[0];
    alloc1     = ~stall & disp_br_req[1];
    alloc_mask = (alloc0 ? p0_oh : '0) | (alloc1 ? p1_oh : '0);
    n_alloc    = stall ? '0 : n_req;

    n_freed = '0;
    for (int i = 0; i < NUM_BS; i++) begin
      n_freed = n_freed + {{PTR_W{1'b0}}, (clr[i] | sq_mask[i])};
    end
  end

  assign disp_stall  = stall;
  assign disp_ptr0   = ptr0;
  assign disp_ptr1   = ptr1;
  assign disp_bmask0 = bm0;
  assign disp_bmask1 = bm1;
  assign cur_bmask   = live_q;
  assign squash_mask = sq_mask;
  assign recov_NPC   = res_recov_NPC;
  assign clear_ptr   = res_ptr;
  assign free_count  = free_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= NORMAL;
      recov_cnt <= '0;
      live_q    <= '0;
      free_q    <= (PTR_W+1)'(NUM_BS);
      for (int i = 0; i < NUM_BS; i++) dep_q[i] <= '0;
    end else begin
      live_q <= (live_q & ~clr & ~sq_mask) | alloc_mask;
      free_q <= free_q - n_alloc + n_freed;
      for (int i = 0; i < NUM_BS; i++) begin
        if (alloc0 && p0_oh[i])      dep_q[i] <= bm0;
        else if (alloc1 && p1_oh[i]) dep_q[i] <= bm1;
        else                         dep_q[i] <= dep_q[i] & ~clr & ~sq_mask;
      end

      // A squash always (re)arms the recovery window, even mid-recovery.
      if (squash) begin
        state     <= RECOVER;
        recov_cnt <= CNT_W'(RECOV_CYCLES - 1);
      end else if (state == RECOVER) begin
        if (recov_cnt == '0) state <= NORMAL;
        else                 recov_cnt <= recov_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_stack_ctrl.sv
// tb/tb_branch_stack_ctrl.sv - directed self-checking bench for branch_stack_ctrl
module tb_branch_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  disp_br_req;
  logic        disp_stall;
  logic [1:0]  disp_ptr0, disp_ptr1;
  logic [3:0]  disp_bmask0, disp_bmask1, cur_bmask;
  logic        res_valid, res_wrong;
  logic [1:0]  res_ptr;
  logic [63:0] res_recov_NPC;
  logic        squash;
  logic [3:0]  squash_mask;
  logic [63:0] recov_NPC;
  logic        clear_valid;
  logic [1:0]  clear_ptr;
  logic [2:0]  free_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_stack_ctrl #(.NUM_BS(4), .PTR_W(2), .RECOV_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .disp_br_req(disp_br_req), .disp_stall(disp_stall),
    .disp_ptr0(disp_ptr0), .disp_ptr1(disp_ptr1), .disp_bmask0(disp_bmask0),
    .disp_bmask1(disp_bmask1), .cur_bmask(cur_bmask), .res_valid(res_valid),
    .res_wrong(res_wrong), .res_ptr(res_ptr), .res_recov_NPC(res_recov_NPC),
    .squash(squash), .squash_mask(squash_mask), .recov_NPC(recov_NPC),
    .clear_valid(clear_valid), .clear_ptr(clear_ptr), .free_count(free_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic res_idle();
    res_valid = 1'b0;
    res_wrong = 1'b0;
    res_ptr   = 2'd0;
  endtask

  task automatic resolve(input logic wrong, input logic [1:0] ptr);
    res_valid = 1'b1;
    res_wrong = wrong;
    res_ptr   = ptr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    disp_br_req = 2'b00;
    res_idle();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    res_recov_NPC = 64'h0;
    do_reset();
    tick();

    // Reset state
    settle();
    chk("rst_cur_bmask", cur_bmask, 4'b0000);
    chk("rst_free", free_count, 3'd4);
    chk("rst_stall", disp_stall, 1'b0);
    chk("rst_squash", squash, 1'b0);
    chk("rst_clear", clear_valid, 1'b0);

    // Two-branch allocation from empty
    disp_br_req = 2'b11;
    settle();
    chk("a_stall", disp_stall, 1'b0);
    chk("a_ptr0", disp_ptr0, 2'd0);
    chk("a_ptr1", disp_ptr1, 2'd1);
    chk("a_bm0", disp_bmask0, 4'b0000);
    chk("a_bm1", disp_bmask1, 4'b0001);
    tick();
    chk("a_cur", cur_bmask, 4'b0011);
    chk("a_free", free_count, 3'd2);

    // Fill remaining two
    settle();
    chk("f_ptr0", disp_ptr0, 2'd2);
    chk("f_ptr1", disp_ptr1, 2'd3);
    chk("f_bm0", disp_bmask0, 4'b0011);
    chk("f_bm1", disp_bmask1, 4'b0111);
    tick();
    disp_br_req = 2'b01;
    settle();
    chk("full_free", free_count, 3'd0);
    chk("full_stall", disp_stall, 1'b1);
    tick();
    chk("full_free_hold", free_count, 3'd0);

    // Correct resolve of 3 -> free_count 1, then 2-wide request must stall
    disp_br_req = 2'b00;
    resolve(1'b0, 2'd3);
    settle();
    chk("c3_clear", clear_valid, 1'b1);
    chk("c3_clear_ptr", clear_ptr, 2'd3);
    chk("c3_squash", squash, 1'b0);
    tick();
    res_idle();
    disp_br_req = 2'b11;
    settle();
    chk("one_free", free_count, 3'd1);
    chk("one_free_stall", disp_stall, 1'b1);
    tick();
    disp_br_req = 2'b00;
    settle();
    chk("one_free_hold", free_count, 3'd1);
    chk("one_free_cur", cur_bmask, 4'b0111);

    // Mispredict of ptr 1 with 0,1,2 live (2 depends on 0,1)
    do_reset();
    disp_br_req = 2'b11;
    tick();
    disp_br_req = 2'b01;
    tick();
    disp_br_req = 2'b00;
    res_recov_NPC = 64'hDEAD_BEEF_0123_4567;
    resolve(1'b1, 2'd1);
    settle();
    chk("m1_squash", squash, 1'b1);
    chk("m1_mask", squash_mask, 4'b0110);
    chk("m1_npc", recov_NPC, 64'hDEAD_BEEF_0123_4567);
    chk("m1_clear", clear_valid, 1'b0);
    chk("m1_stall", disp_stall, 1'b1);
    tick();
    res_idle();
    settle();
    chk("m1_cur", cur_bmask, 4'b0001);
    chk("m1_free", free_count, 3'd3);
    chk("m1_rec_stall0", disp_stall, 1'b1);
    tick();
    chk("m1_rec_stall1", disp_stall, 1'b1);
    tick();
    chk("m1_rec_done", disp_stall, 1'b0);

    // Correct resolve of 0 alongside slot-0 branch dispatch
    do_reset();
    disp_br_req = 2'b11;
    tick();
    disp_br_req = 2'b01;
    resolve(1'b0, 2'd0);
    settle();
    chk("cd_clear", clear_valid, 1'b1);
    chk("cd_clear_ptr", clear_ptr, 2'd0);
    chk("cd_stall", disp_stall, 1'b0);
    chk("cd_ptr0", disp_ptr0, 2'd2);
    chk("cd_bm0", disp_bmask0, 4'b0010);
    tick();
    disp_br_req = 2'b00;
    res_idle();
    settle();
    chk("cd_cur", cur_bmask, 4'b0110);
    chk("cd_free", free_count, 3'd2);
    // Entry 2 was born depending only on 1: squashing 1 takes 2 with it.
    resolve(1'b1, 2'd1);
    settle();
    chk("cd_dep_mask", squash_mask, 4'b0110);
    res_idle();

    // Mispredict of 0 with a simultaneous 2-wide request; stale resolves
    do_reset();
    disp_br_req = 2'b11;
    tick();
    disp_br_req = 2'b01;
    tick();
    disp_br_req = 2'b11;
    resolve(1'b1, 2'd0);
    settle();
    chk("ms_squash", squash, 1'b1);
    chk("ms_mask", squash_mask, 4'b0111);
    chk("ms_stall", disp_stall, 1'b1);
    tick();
    disp_br_req = 2'b00;
    res_idle();
    settle();
    chk("ms_cur", cur_bmask, 4'b0000);
    chk("ms_free", free_count, 3'd4);
    tick();
    tick();
    resolve(1'b1, 2'd2);
    settle();
    chk("stale_squash", squash, 1'b0);
    chk("stale_stall", disp_stall, 1'b0);
    resolve(1'b0, 2'd2);
    settle();
    chk("stale_clear", clear_valid, 1'b0);
    tick();
    res_idle();
    settle();
    chk("stale_free", free_count, 3'd4);
    chk("stale_cur", cur_bmask, 4'b0000);
    chk("stale_nostall", disp_stall, 1'b0);

    // Second squash on first RECOVER cycle reloads the counter
    do_reset();
    disp_br_req = 2'b11;
    tick();
    disp_br_req = 2'b00;
    resolve(1'b1, 2'd1);
    tick();
    resolve(1'b1, 2'd0);
    settle();
    chk("rr_stall_first", disp_stall, 1'b1);
    chk("rr_squash2", squash, 1'b1);
    chk("rr_mask2", squash_mask, 4'b0001);
    tick();
    res_idle();
    settle();
    chk("rr_stall_a", disp_stall, 1'b1);
    chk("rr_free", free_count, 3'd4);
    tick();
    chk("rr_stall_b", disp_stall, 1'b1);
    tick();
    chk("rr_stall_done", disp_stall, 1'b0);

    // Reset during RECOVER with a live entry
    disp_br_req = 2'b11;
    tick();
    disp_br_req = 2'b00;
    resolve(1'b1, 2'd1);
    tick();
    res_idle();
    settle();
    chk("rr2_cur", cur_bmask, 4'b0001);
    chk("rr2_stall", disp_stall, 1'b1);
    do_reset();
    settle();
    chk("rst_rec_stall", disp_stall, 1'b0);
    chk("rst_rec_free", free_count, 3'd4);
    chk("rst_rec_cur", cur_bmask, 4'b0000);

    // Only slot 1 requests: takes lowest free index
    disp_br_req = 2'b10;
    settle();
    chk("s1_ptr1", disp_ptr1, 2'd0);
    chk("s1_bm1", disp_bmask1, 4'b0000);
    tick();
    disp_br_req = 2'b00;
    settle();
    chk("s1_cur", cur_bmask, 4'b0001);
    chk("s1_free", free_count, 3'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_stack_ctrl.md
Name: branch_stack_ctrl

Overview:
Allocates and retires branch-stack (checkpoint) entries for the 2-way dispatch stage. Generates the BS_PTR and B_MASK attached to each dispatched branch, and tracks which older branches each entry depends on. Consumes the registered resolution outputs of the branch FU and broadcasts either clear (correct) or squash (mispredict) masks to the RS/ROB/FUs. A small FSM holds dispatch off for a fixed window after a mispredict while the front end redirects.

Parameters:
NUM_BS, 4, number of branch-stack entries (B_MASK width)
PTR_W, 2, BS_PTR width, $clog2(NUM_BS)
RECOV_CYCLES, 2, dispatch-blocking cycles after a squash (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
disp_br_req  in  2  bit i = dispatch slot i carries a branch this cycle
disp_stall  out  1  dispatch must hold; no allocation this cycle
disp_ptr0  out  PTR_W  entry granted to slot 0
disp_ptr1  out  PTR_W  entry granted to slot 1
disp_bmask0  out  NUM_BS  older unresolved branches for slot 0 (own bit excluded)
disp_bmask1  out  NUM_BS  older unresolved branches for slot 1 (includes slot-0 bit if slot 0 is a branch)
cur_bmask  out  NUM_BS  registered mask of all live branches, for non-branch dispatch
res_valid  in  1  branch FU br_branch_resolved
res_wrong  in  1  branch FU br_pred_wrong
res_ptr  in  PTR_W  branch FU br_bs_ptr
res_recov_NPC  in  64  branch FU br_recov_NPC
squash  out  1  combinational: res_valid & res_wrong & entry live
squash_mask  out  NUM_BS  entry res_ptr plus every live entry whose dep mask has bit res_ptr
recov_NPC  out  64  pass-through of res_recov_NPC, valid with squash
clear_valid  out  1  combinational: res_valid & !res_wrong & entry live
clear_ptr  out  PTR_W  equals res_ptr
free_count  out  PTR_W+1  number of free entries (registered)

Behaviour:
- State per entry: valid bit, dep mask[NUM_BS]. FSM: NORMAL, RECOVER, with a down-counter.
- Reset: all entries invalid, dep masks 0, cur_bmask 0, free_count NUM_BS, FSM NORMAL, counter 0. disp_stall=0 unless requests exceed free entries. squash and clear_valid are 0 when res_valid=0.
- Allocation uses the lowest free index for the first requesting slot and the next lowest for the second. If only slot 1 requests, it takes the lowest free index.
- Entries freed this cycle are not allocatable until the next cycle.
- All-or-nothing: if popcount(disp_br_req) > free_count, or FSM=RECOVER, or squash=1 this cycle, then disp_stall=1 and no entry is allocated. disp_ptr/disp_bmask outputs are don't-care while stalled.
- Granted dep masks: disp_bmask0 = cur_bmask & ~clr, where clr is the one-hot of res_ptr when clear_valid, else 0. disp_bmask1 = disp_bmask0 | (onehot(disp_ptr0) if slot 0 requested).
- cur_bmask next = (cur_bmask & ~clr & ~squash_mask) | newly allocated bits.
- Correct resolution (clear_valid): the entry is freed next cycle, and bit res_ptr is cleared from every dep mask and from cur_bmask.
- Mispredict (squash): all squash_mask entries are freed next cycle. Remaining entries keep their dep masks with squash_mask bits cleared. The FSM moves to RECOVER with counter=RECOV_CYCLES-1.
- RECOVER: disp_stall=1. The counter decrements each cycle; return to NORMAL when counter==0. A new squash while in RECOVER reloads the counter.
- res_valid on an invalid entry (already squashed) is ignored: no squash, no clear, no state change.
- Resolution is processed before allocation in the same cycle. A simultaneous correct clear and dispatch gives new masks without the cleared bit.
- free_count next = free_count - allocated + freed. Range 0..NUM_BS, never wraps.
- Reset mid-RECOVER or with live entries restores the reset state on the next edge.

Test Plan:
- Reset, then disp_br_req=2'b11 -> disp_ptr0=0, disp_ptr1=1, disp_bmask0=0000, disp_bmask1=0001; next cycle cur_bmask=0011, free_count=2.
- Fill all 4 entries, then disp_br_req=2'b01 -> disp_stall=1; with free_count=1 and disp_br_req=2'b11 -> disp_stall=1 and no allocation (free_count stays 1).
- Entries 0,1,2 live in program order (2 depends on 0,1); res_valid=1, res_wrong=1, res_ptr=1 -> squash=1, squash_mask=0110, recov_NPC=res_recov_NPC; next cycle cur_bmask=0001, free_count=3; disp_stall=1 for 2 cycles, then 0.
- Entries 0,1 live; correct resolution of ptr 0 in the same cycle as slot-0 branch dispatch -> clear_valid=1, clear_ptr=0, disp_ptr0=2, disp_bmask0=0010; next cycle cur_bmask=0110.
- Mispredict on ptr 0 in the same cycle as disp_br_req=2'b11 -> disp_stall=1, no allocation; a later res_valid on a squashed ptr -> squash=0, clear_valid=0, state unchanged.
- Second mispredict on the first RECOVER cycle -> counter reloads; disp_stall stays high for RECOV_CYCLES cycles after the second squash. Assert reset during RECOVER -> next cycle FSM=NORMAL, free_count=4, cur_bmask=0.
